// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   8N1 UART transmitter fed by a small byte FIFO. Bytes pushed from the
//   CPU/MMIO side are sent as start bit, 8 data bits LSB first, stop bit.
//   Frames go out back-to-back while the FIFO holds data. The baud divisor
//   is captured at every frame start, so rewriting baud_DB never disturbs
//   a frame already on the line.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   baud_DB   bit period minus one, in clk cycles
//   tx_data   byte to enqueue
//   wr_en     enqueue strobe; ignored while tx_full is high
//   tx_full   FIFO holds DEPTH entries
//   tx_empty  FIFO holds no entries (a frame may still be on the line)
//   tx_busy   a frame is being transmitted
//   tx_done   one-cycle pulse when a stop bit completes
//   TX        registered serial output, idles high
module uart_tx_buffered #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] baud_DB,
  input  logic [7:0]  tx_data,
  input  logic        wr_en,
  output logic        tx_full,
  output logic        tx_empty,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        TX
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    TX_STATE
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Serialiser
  logic [9:0]  shifter;
  logic [12:0] baud_cnt;
  logic [12:0] div_q;
  logic [3:0]  bit_cnt;
  logic        tx_q;
  logic        done_q;

  // FSM decisions
  logic load_frame;
  logic shift_bit;
  logic finish_frame;

  assign tx_full  = (count == FULL_CNT);
  assign tx_empty = (count == '0);
  assign tx_busy  = (state_q == TX_STATE);
  assign tx_done  = done_q;
  assign TX       = tx_q;

  // A write is dropped when the FIFO was full at the start of the cycle,
  // even if a pop frees a slot on the same edge.
  assign push = wr_en && !tx_full;
  assign pop  = load_frame;

  // --------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------
  // FSM next-state and control decode
  // --------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    load_frame   = 1'b0;
    shift_bit    = 1'b0;
    finish_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          load_frame = 1'b1;
          state_d    = TX_STATE;
        end
      end
      TX_STATE: begin
        if (baud_cnt == '0) begin
          if (bit_cnt == 4'd9) begin
            // Stop bit has run its full period.
            finish_frame = 1'b1;
            if (!tx_empty) begin
              load_frame = 1'b1;   // chain the next frame, no idle gap
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every flop sees pre-edge values of its neighbours.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; reset clears the pointers and
  // count, which is enough to make every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // --------------------------------------------------------------------
  // Serialiser datapath
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter  <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      div_q    <= baud_DB;  // stored divisor tracks the input while in reset
      tx_q     <= 1'b1;     // line goes high at once, no partial stop bit
      done_q   <= 1'b0;
    end else begin
      done_q <= finish_frame;
      if (load_frame) begin
        // Frame image {stop, data, start}; bit 0 is always what TX shows.
        shifter  <= {1'b1, mem[rd_ptr], 1'b0};
        div_q    <= baud_DB;
        baud_cnt <= baud_DB;
        bit_cnt  <= '0;
        tx_q     <= 1'b0;
      end else if (shift_bit) begin
        shifter  <= {1'b1, shifter[9:1]};
        baud_cnt <= div_q;
        bit_cnt  <= bit_cnt + 1'b1;
        tx_q     <= shifter[1];
      end else if (finish_frame) begin
        tx_q <= 1'b1;         // last frame done, back to idle level
      end else if (state_q == TX_STATE) begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
//   Randomised and directed stimulus for uart_tx_buffered, checked every
//   cycle against a frame-level reference model: a byte queue plus, for the
//   frame on the line, its byte, divisor and elapsed cycle count. The
//   expected TX level is bit number (elapsed / bit_period) of the 8N1 frame.
module tb_uart_tx_buffered;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [12:0] baud_DB;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_busy;
  logic        tx_done;
  logic        TX;

  uart_tx_buffered #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_DB  (baud_DB),
    .tx_data  (tx_data),
    .wr_en    (wr_en),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .TX       (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [7:0] mq[$];
  bit         m_active;
  logic [7:0] m_byte;
  int         m_div;
  int         m_t;
  bit         m_done;

  function automatic void model_reset();
    mq.delete();
    m_active = 0;
    m_byte   = '0;
    m_div    = 0;
    m_t      = 0;
    m_done   = 0;
  endfunction

  // Advance the model by one clock edge given the inputs sampled there.
  function automatic void model_edge(input logic wr, input logic [7:0] d, input logic [12:0] b);
    bit was_full;
    was_full = (mq.size() == DEPTH);
    m_done   = 0;
    if (m_active) begin
      m_t++;
      if (m_t == 10 * (m_div + 1)) begin
        m_done   = 1;
        m_active = 0;
      end
    end
    if (!m_active && mq.size() != 0) begin
      m_byte   = mq.pop_front();
      m_div    = int'(b);
      m_t      = 0;
      m_active = 1;
    end
    if (wr && !was_full) mq.push_back(d);
  endfunction

  // Expected {TX, busy, done, empty, full} after the last modelled edge.
  function automatic logic [4:0] m_outs();
    logic txv;
    int   k;
    txv = 1'b1;
    if (m_active) begin
      k = m_t / (m_div + 1);
      if (k == 0)      txv = 1'b0;
      else if (k == 9) txv = 1'b1;
      else             txv = m_byte[k-1];
    end
    return {txv, m_active, m_done, (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  // ------------------------------------------------------------------
  // Cycle stepping
  // ------------------------------------------------------------------
  int cyc = 0;
  int busy_cnt;
  int done_cyc[$];

  task automatic clear_stats();
    busy_cnt = 0;
    done_cyc.delete();
  endtask

  task automatic step();
    model_edge(wr_en, tx_data, baud_DB);
    @(posedge clk);
    #1;
    cyc++;
    check("outs{tx,busy,done,empty,full}",
          32'({TX, tx_busy, tx_done, tx_empty, tx_full}), 32'(m_outs()));
    if (tx_busy) busy_cnt++;
    if (tx_done) done_cyc.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    tx_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  function automatic int done_gap();
    if (done_cyc.size() >= 2) return done_cyc[1] - done_cyc[0];
    return -1;
  endfunction

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    tx_data = '0;
    baud_DB = 13'd3;
    model_reset();
    clear_stats();
    #23;
    check("reset_outs", 32'({TX, tx_busy, tx_done, tx_empty, tx_full}), 32'(5'b10010));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single frame 0xA5 at 4 cycles per bit
    clear_stats();
    baud_DB = 13'd3;
    push_byte(8'hA5);
    check("t1_empty_after_write", 32'(tx_empty), 32'd0);
    check("t1_tx_before_start", 32'(TX), 32'd1);
    step();
    check("t1_tx_start_bit", 32'(TX), 32'd0);
    run(48);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd40);
    check("t1_done_pulses", 32'(done_cyc.size()), 32'd1);

    // 2: back-to-back frames at 3 cycles per bit
    clear_stats();
    baud_DB = 13'd2;
    push_byte(8'h00);
    push_byte(8'hFF);
    run(70);
    check("t2_done_pulses", 32'(done_cyc.size()), 32'd2);
    check("t2_done_gap", 32'(done_gap()), 32'd30);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd60);

    // 3: overflow, six writes into a four-deep FIFO, 0x15 must be dropped
    clear_stats();
    baud_DB = 13'd100;
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h10 + 8'(i));
      if (i == 4) check("t3_full_after_5th", 32'(tx_full), 32'd1);
    end
    check("t3_full_after_6th", 32'(tx_full), 32'd1);
    run(5 * 1010 + 20);
    check("t3_done_pulses", 32'(done_cyc.size()), 32'd5);

    // 4: divisor rewritten during data bit 3 of the first frame
    clear_stats();
    baud_DB = 13'd7;
    push_byte(8'h5A);
    push_byte(8'hC3);
    run(32);
    baud_DB = 13'd3;
    run(130);
    check("t4_done_pulses", 32'(done_cyc.size()), 32'd2);
    check("t4_second_frame_len", 32'(done_gap()), 32'd40);

    // 5: asynchronous reset during data bit 3
    clear_stats();
    baud_DB = 13'd3;
    push_byte(8'h96);
    push_byte(8'h0F);
    run(18);
    check("t5_busy_before_reset", 32'(tx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(TX), 32'd1);
    check("t5_rst_empty", 32'(tx_empty), 32'd1);
    check("t5_rst_busy", 32'(tx_busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    run(30);
    check("t5_idle_tx", 32'(TX), 32'd1);
    check("t5_idle_no_busy", 32'(busy_cnt), 32'd0);

    // 6: one cycle per bit
    clear_stats();
    baud_DB = 13'd0;
    push_byte(8'h3C);
    run(15);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd10);
    check("t6_done_pulses", 32'(done_cyc.size()), 32'd1);

    // Random traffic with occasional divisor rewrites
    clear_stats();
    baud_DB = 13'd1;
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      if ($urandom_range(0, 63) == 0) baud_DB = 13'($urandom_range(0, 4));
      step();
    end
    wr_en = 1'b0;
    run(600);
    check("rand_drained_empty", 32'(tx_empty), 32'd1);
    check("rand_drained_idle", 32'(tx_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
